vdp_cpu_port: RTL
=================

// Module: vdp_cpu_port
// PURPOSE
//  CPU-side I/O responder of the MSX VDP (TMS9918 ports 0x98 data / 0x99 control); the writer feeding the video block.
//  Decodes Z80 port accesses into VRAM port-A reads/writes with 14-bit auto-increment, loads VDP registers R0-R7,
//  and returns the status register. Drives the table addresses, mode and colours consumed by the video block.
// PARAMETERS
//  ADDR_W   14   VRAM address width; address counter wraps at 2**ADDR_W
// PORTS
//  clk                        in   1   single clock (CPU clock; same clock as VRAM port A)
//  n_reset                    in   1   asynchronous active-low reset
//  cpu_sel                    in   1   one-cycle access strobe
//  cpu_wr / cpu_rd            in   1   access direction, sampled with cpu_sel (both high: write wins)
//  cpu_port                   in   1   0 = data port, 1 = control/status port
//  cpu_din                    in   8   write data
//  cpu_dout                   out  8   read data, registered, valid the cycle after cpu_sel
//  cpu_wait                   out  1   high while an access is pending behind a VRAM prefetch
//  vram_addr                  out  14  VRAM port-A address
//  vram_din                   out  8   VRAM write data
//  vram_wr / vram_rd          out  1   one-cycle VRAM write / read strobes
//  vram_dout                  in   8   VRAM read data, valid one cycle after vram_rd
//  mode                       out  2   0 text(M1), 1 graphics I, 2 graphics II(M3), 3 multicolour(M2); priority M1>M2>M3
//  video_on, vert_retrace_int, sprite_large, sprite_enlarged  out 1   R1[6], R1[5], R1[1], R1[0]
//  name_table_addr            out  14  {R2[3:0],10'b0}
//  color_table_addr           out  14  mode 2: {R3[7],13'b0}; else {R3,6'b0}
//  font_addr                  out  14  mode 2: {R4[2],13'b0}; else {R4[2:0],11'b0}
//  sprite_attr_addr           out  14  {R5[6:0],7'b0}
//  sprite_pattern_table_addr  out  14  {R6[2:0],11'b0}
//  text_color / back_color    out  4   R7[7:4] / R7[3:0]
//  interrupt_flag, sprite_collision, too_many_sprites  in 1   event inputs from video block
//  sprite5                    in   5   fifth-sprite number from video block
// BEHAVIOUR
//  - Reset: R0-R7=0 (mode=1, all addrs 0, video_on=0), addr counter=0, read buffer=0, latch phase=0, status=0,
//    cpu_dout=0, vram_wr=vram_rd=0, cpu_wait=0, FSM=IDLE. Reset mid-prefetch aborts it; no strobe after release.
//  - Control write, phase 0: latch cpu_din, phase<=1. Phase 1: phase<=0; if din[7]=1: R[din[2:0]]<=latched byte;
//    else addr<={din[5:0],latched}; if din[6]=0 start prefetch (read-ahead).
//  - Data write: vram_wr pulse with vram_addr=addr, vram_din=cpu_din; read buffer<=cpu_din; addr++; phase<=0.
//  - Data read: cpu_dout<=read buffer; addr++; start prefetch at new addr; phase<=0.
//  - Status read: cpu_dout<={F,5S,C,fifth}; then F,5S,C cleared; phase<=0. Event input asserted in the same
//    cycle as the read sets its bit afterwards (set wins, not lost).
//  - Status latching: F set on interrupt_flag; C set on sprite_collision; 5S and fifth<=sprite5 set on
//    too_many_sprites only while 5S=0 (first report held). fifth otherwise tracks sprite5.
//  - Prefetch FSM: IDLE -> RD (vram_rd=1, vram_addr=addr) -> CAP (read buffer<=vram_dout) -> IDLE. 2 cycles.
//  - Access arriving in RD/CAP: captured in one-deep pending slot, cpu_wait=1, executed in first IDLE cycle.
//    Second access while slot full is dropped (CPU contract: >=3 cycles between accesses).
//  - Address arithmetic modulo 2**ADDR_W: 0x3FFF+1 -> 0x0000. Register index 7 selects R7; din[6:3] ignored.
// STRUCTURE
//  - Shared vdp_defs.vh: register indices, R1 bit positions, status bit positions, mode encodings (also used by video).
//  - One sub-module natural: vdp_status_reg (sticky F/C/5S/fifth latch with read-clear). FSM stays inline.
// TESTING
//  - Reset: n_reset low mid-RD -> all outputs 0, mode=1, no vram_rd after release.
//  - Ctrl 0x0F,0x87 -> back_color=F, text_color=0. Ctrl 0x06,0x82 -> name_table_addr=0x1800.
//  - Ctrl 0xFF,0x7F then data 0xAA,0x55 -> vram writes 0x3FFF=0xAA, 0x0000=0x55; addr=0x0001.
//  - VRAM[0x1234]=0x5A,[0x1235]=0xA5; ctrl 0x34,0x12; data reads -> 0x5A then 0xA5; one vram_rd per step.
//  - interrupt_flag pulse, status read -> 0x80; second read -> 0x00; ctrl phase reset after read.
//  - Data read followed 1 cycle later by data read -> cpu_wait high 1-2 cycles, second returns prefetched byte.

Source files
------------

// File: rtl/vdp_cpu_port_pkg.sv
// Shared VDP definitions: register indices, control bit positions, display modes and CPU access payload.
package vdp_cpu_port_pkg;

    localparam int unsigned VRAM_ADDR_W = 14;
    localparam int unsigned TBL_ADDR_W  = 14;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned SPR_W       = 5;

    localparam int unsigned REG_MODE0   = 0;
    localparam int unsigned REG_MODE1   = 1;
    localparam int unsigned REG_NAME    = 2;
    localparam int unsigned REG_COLOR   = 3;
    localparam int unsigned REG_FONT    = 4;
    localparam int unsigned REG_SATTR   = 5;
    localparam int unsigned REG_SPAT    = 6;
    localparam int unsigned REG_COLORS  = 7;

    localparam int unsigned R0_M3       = 1;
    localparam int unsigned R1_BLANK    = 6;
    localparam int unsigned R1_IE       = 5;
    localparam int unsigned R1_M1       = 4;
    localparam int unsigned R1_M2       = 3;
    localparam int unsigned R1_SIZE     = 1;
    localparam int unsigned R1_MAG      = 0;

    typedef enum logic [1:0] {
        MODE_TEXT  = 2'd0,
        MODE_GFX1  = 2'd1,
        MODE_GFX2  = 2'd2,
        MODE_MULTI = 2'd3
    } vdp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic       wr;
        logic       port;
        logic [7:0] din;
    } cpu_acc_t;

    // Mode bit priority: M1 (text) over M2 (multicolour) over M3 (graphics II).
    function automatic vdp_mode_e decode_mode(input logic m1, input logic m2, input logic m3);
        if (m1)      return MODE_TEXT;
        else if (m2) return MODE_MULTI;
        else if (m3) return MODE_GFX2;
        else         return MODE_GFX1;
    endfunction

endpackage

// File: rtl/vdp_cpu_port_status.sv
// Sticky VDP status latch: F / C / 5S flags and fifth-sprite number, cleared by a status read.
module vdp_cpu_port_status
    import vdp_cpu_port_pkg::*;
(
    input  logic             clk,
    input  logic             n_reset,
    input  logic             rd_clr,
    input  logic             interrupt_flag,
    input  logic             sprite_collision,
    input  logic             too_many_sprites,
    input  logic [SPR_W-1:0] sprite5,
    output logic [7:0]       status
);

    logic             flag_f;
    logic             flag_c;
    logic             flag_5s;
    logic [SPR_W-1:0] fifth;
    logic             hold_5s_c;

    // The first fifth-sprite report is frozen until software reads it.
    assign hold_5s_c = flag_5s & ~rd_clr;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            flag_f  <= 1'b0;
            flag_c  <= 1'b0;
            flag_5s <= 1'b0;
            fifth   <= '0;
        end else begin
            flag_f  <= interrupt_flag | (flag_f & ~rd_clr);
            flag_c  <= sprite_collision | (flag_c & ~rd_clr);
            flag_5s <= too_many_sprites | hold_5s_c;
            if (!hold_5s_c) begin
                fifth <= sprite5;
            end
        end
    end

    assign status = {flag_f, flag_5s, flag_c, fifth};

endmodule

// File: rtl/vdp_cpu_port.sv
// Z80-facing VDP port: VRAM access with auto-increment and read-ahead, register loads, status readback.
module vdp_cpu_port
    import vdp_cpu_port_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  cpu_sel,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic                  cpu_port,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  cpu_wait,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_din,
    output logic                  vram_wr,
    output logic                  vram_rd,
    input  logic [7:0]            vram_dout,
    output logic [1:0]            mode,
    output logic                  video_on,
    output logic                  vert_retrace_int,
    output logic                  sprite_large,
    output logic                  sprite_enlarged,
    output logic [TBL_ADDR_W-1:0] name_table_addr,
    output logic [TBL_ADDR_W-1:0] color_table_addr,
    output logic [TBL_ADDR_W-1:0] font_addr,
    output logic [TBL_ADDR_W-1:0] sprite_attr_addr,
    output logic [TBL_ADDR_W-1:0] sprite_pattern_table_addr,
    output logic [3:0]            text_color,
    output logic [3:0]            back_color,
    input  logic                  interrupt_flag,
    input  logic                  sprite_collision,
    input  logic                  too_many_sprites,
    input  logic [SPR_W-1:0]      sprite5
);

    pf_state_e                  state;
    logic [NUM_REGS-1:0][7:0]   regs;
    logic [ADDR_W-1:0]          addr_q;
    logic [7:0]                 rbuf;
    logic [7:0]                 latch;
    logic                       phase;
    cpu_acc_t                   pend;
    logic                       pend_valid;

    logic                       req_c;
    cpu_acc_t                   req_acc_c;
    cpu_acc_t                   exec_c;
    logic                       exec_valid_c;
    logic                       stat_clr_c;
    logic [7:0]                 status_c;
    logic [ADDR_W-1:0]          addr_set_c;
    logic [ADDR_W-1:0]          addr_inc_c;
    vdp_mode_e                  mode_c;
    logic                       unused_regs_c;

    assign req_c      = cpu_sel & (cpu_wr | cpu_rd);
    assign req_acc_c  = '{wr: cpu_wr, port: cpu_port, din: cpu_din};
    assign addr_set_c = ADDR_W'({exec_c.din[5:0], latch});
    assign addr_inc_c = addr_q + ADDR_W'(1);
    assign stat_clr_c = exec_valid_c & ~exec_c.wr & exec_c.port;

    // A parked access takes precedence; a fresh one is only executed when nothing is parked.
    always_comb begin
        exec_c       = '0;
        exec_valid_c = 1'b0;
        if (state == ST_IDLE) begin
            if (pend_valid) begin
                exec_c       = pend;
                exec_valid_c = 1'b1;
            end else if (req_c) begin
                exec_c       = req_acc_c;
                exec_valid_c = 1'b1;
            end
        end
    end

    vdp_cpu_port_status u_status (
        .clk              (clk),
        .n_reset          (n_reset),
        .rd_clr           (stat_clr_c),
        .interrupt_flag   (interrupt_flag),
        .sprite_collision (sprite_collision),
        .too_many_sprites (too_many_sprites),
        .sprite5          (sprite5),
        .status           (status_c)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_IDLE;
            regs       <= '0;
            addr_q     <= '0;
            rbuf       <= '0;
            latch      <= '0;
            phase      <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
            cpu_dout   <= '0;
            cpu_wait   <= 1'b0;
            vram_addr  <= '0;
            vram_din   <= '0;
            vram_wr    <= 1'b0;
            vram_rd    <= 1'b0;
        end else begin
            vram_wr <= 1'b0;
            vram_rd <= 1'b0;

            // Park one access that arrives while the read-ahead owns VRAM.
            if (state != ST_IDLE && req_c && !pend_valid) begin
                pend       <= req_acc_c;
                pend_valid <= 1'b1;
                cpu_wait   <= 1'b1;
            end

            case (state)
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    rbuf  <= vram_dout;
                    state <= ST_IDLE;
                end
                default: begin
                    if (exec_valid_c) begin
                        pend_valid <= 1'b0;
                        cpu_wait   <= 1'b0;
                        if (exec_c.wr && exec_c.port) begin
                            if (!phase) begin
                                latch <= exec_c.din;
                                phase <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (exec_c.din[7]) begin
                                    regs[exec_c.din[2:0]] <= latch;
                                end else begin
                                    addr_q <= addr_set_c;
                                    if (!exec_c.din[6]) begin
                                        vram_addr <= addr_set_c;
                                        vram_rd   <= 1'b1;
                                        state     <= ST_RD;
                                    end
                                end
                            end
                        end else if (exec_c.wr) begin
                            vram_wr   <= 1'b1;
                            vram_addr <= addr_q;
                            vram_din  <= exec_c.din;
                            rbuf      <= exec_c.din;
                            addr_q    <= addr_inc_c;
                            phase     <= 1'b0;
                        end else if (!exec_c.port) begin
                            cpu_dout  <= rbuf;
                            addr_q    <= addr_inc_c;
                            vram_addr <= addr_inc_c;
                            vram_rd   <= 1'b1;
                            state     <= ST_RD;
                            phase     <= 1'b0;
                        end else begin
                            cpu_dout <= status_c;
                            phase    <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Register fields decoded for the video block.
    assign mode_c           = decode_mode(regs[REG_MODE1][R1_M1], regs[REG_MODE1][R1_M2], regs[REG_MODE0][R0_M3]);
    assign mode             = mode_c;
    assign video_on         = regs[REG_MODE1][R1_BLANK];
    assign vert_retrace_int = regs[REG_MODE1][R1_IE];
    assign sprite_large     = regs[REG_MODE1][R1_SIZE];
    assign sprite_enlarged  = regs[REG_MODE1][R1_MAG];

    assign name_table_addr  = {regs[REG_NAME][3:0], 10'b0};
    assign color_table_addr = (mode_c == MODE_GFX2) ? {regs[REG_COLOR][7], 13'b0}
                                                    : {regs[REG_COLOR], 6'b0};
    assign font_addr        = (mode_c == MODE_GFX2) ? {regs[REG_FONT][2], 13'b0}
                                                    : {regs[REG_FONT][2:0], 11'b0};
    assign sprite_attr_addr          = {regs[REG_SATTR][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs[REG_SPAT][2:0], 11'b0};
    assign text_color       = regs[REG_COLORS][7:4];
    assign back_color       = regs[REG_COLORS][3:0];

    // Several register bits are reserved in this VDP generation.
    assign unused_regs_c    = ^regs;

endmodule
